dmem_responder: RTL and testbench

- Data-memory responder at the far end of the processor's load/store path.
- Accepts one ldr/str request at a time from the writeback stage over a valid/ready handshake.
- Services the request against an internal word-addressed array after a fixed latency.
- Returns a response carrying load data and destination register tag, held until the requester takes it.

---
 rtl/dmem_responder_if.sv | 36 +++
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// | Module   : dmem_responder_if                                            |
// | Purpose  : request/response bundle between the writeback stage and the  |
// |            data-memory responder.                                       |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_dest;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_data;
   logic [3:0]        rsp_dest;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_dest, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_data, rsp_dest
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_dest, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_data, rsp_dest
   );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// | Module   : dmem_responder                                               |
// | Purpose  : single-outstanding ldr/str responder over a word array with  |
// |            fixed commit latency. DMEM_STATS_EN adds commit/stall counts.|
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 2
) (
   input  wire logic         clk,
   input  wire logic         reset,
   dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]       load_count,
   output logic [15:0]       store_count,
   output logic [15:0]       stall_count
`endif
);

   localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);
   localparam int         C_DEPTH    = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        dest_q, dest_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]        rsp_dest_q, rsp_dest_d;

   logic [DATA_W-1:0] mem_q [0:C_DEPTH-1];

   logic              w_commit;
   logic              w_c_write;
   logic [ADDR_W-1:0] w_c_addr;
   logic [DATA_W-1:0] w_c_wdata;
   logic [3:0]        w_c_dest;
   logic [DATA_W-1:0] w_rdata;

   // With LATENCY=1 the commit coincides with the accept edge, so the live
   // request fields are used instead of the (not yet loaded) latches.
   always_comb begin
      w_commit  = 1'b0;
      w_c_write = write_q;
      w_c_addr  = addr_q;
      w_c_wdata = wdata_q;
      w_c_dest  = dest_q;
      if (state_q == S_IDLE) begin
         w_c_write = bus.req_write;
         w_c_addr  = bus.req_addr;
         w_c_wdata = bus.req_wdata;
         w_c_dest  = bus.req_dest;
         w_commit  = bus.req_valid && (LATENCY == 1);
      end else if (state_q == S_BUSY) begin
         w_commit  = (cnt_q == 4'd1);
      end
   end

   assign w_rdata = mem_q[w_c_addr];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      dest_d      = dest_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_data_d  = rsp_data_q;
      rsp_dest_d  = rsp_dest_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               dest_d  = bus.req_dest;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  cnt_d   = C_CNT_LOAD;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (w_commit) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = w_c_write;
         rsp_dest_d  = w_c_dest;
         rsp_data_d  = w_c_write ? w_c_wdata : w_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         dest_q      <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_dest_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         dest_q      <= dest_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_data_q  <= rsp_data_d;
         rsp_dest_q  <= rsp_dest_d;
      end
   end

   // Array is never cleared; reset only blocks a store from landing.
   always_ff @(posedge clk) begin
      if (!reset && w_commit && w_c_write) begin
         mem_q[w_c_addr] <= w_c_wdata;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_dest  = rsp_dest_q;

`ifdef DMEM_STATS_EN
   logic [15:0] load_count_q, store_count_q, stall_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         load_count_q  <= 16'd0;
         store_count_q <= 16'd0;
         stall_count_q <= 16'd0;
      end else begin
         if (w_commit && !w_c_write && load_count_q != 16'hFFFF) begin
            load_count_q <= load_count_q + 16'd1;
         end
         if (w_commit && w_c_write && store_count_q != 16'hFFFF) begin
            store_count_q <= store_count_q + 16'd1;
         end
         if (state_q == S_RESP && !bus.rsp_ready && stall_count_q != 16'hFFFF) begin
            stall_count_q <= stall_count_q + 16'd1;
         end
      end
   end

   assign load_count  = load_count_q;
   assign store_count = store_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// | Module   : tb_dmem_responder                                            |
// | Purpose  : directed checks of dmem_responder at LATENCY=2 and LATENCY=1.|
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

   logic clk;
   logic reset;
   int   err_cnt;
   int   chk_cnt;

   dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();
   dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

`ifdef DMEM_STATS_EN
   logic [15:0] load_count, store_count, stall_count;
   logic [15:0] load_count1, store_count1, stall_count1;
`endif

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(2)) u_dut2 (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus2.slave)
`ifdef DMEM_STATS_EN
      ,
      .load_count  (load_count),
      .store_count (store_count),
      .stall_count (stall_count)
`endif
   );

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut1 (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus1.slave)
`ifdef DMEM_STATS_EN
      ,
      .load_count  (load_count1),
      .store_count (store_count1),
      .stall_count (stall_count1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full LATENCY=2 transaction; lat counts edges from accept to rsp_valid.
   task automatic xact2(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] dst, input int n_stall, input logic [15:0] exp_d,
                        output logic [15:0] rd, output logic rw, output logic [3:0] rdst,
                        output int lat);
      int n;
      bus2.rsp_ready = (n_stall == 0);
      bus2.req_valid = 1'b1;
      bus2.req_write = w;
      bus2.req_addr  = a;
      bus2.req_wdata = d;
      bus2.req_dest  = dst;
      n = 0;
      while (!bus2.req_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check_value("req_ready_timeout", 32'd0, 32'd1);
      tick();
      bus2.req_valid = 1'b0;
      lat = 1;
      while (!bus2.rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!bus2.rsp_valid) check_value("rsp_valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < n_stall; i++) begin
         check_value("stall_rsp_valid", 32'(bus2.rsp_valid), 32'd1);
         check_value("stall_rsp_data", 32'(bus2.rsp_data), 32'(exp_d));
         check_value("stall_req_ready", 32'(bus2.req_ready), 32'd0);
         tick();
      end
      rd   = bus2.rsp_data;
      rw   = bus2.rsp_write;
      rdst = bus2.rsp_dest;
      bus2.rsp_ready = 1'b1;
      tick();
      check_value("req_ready_after_handoff", 32'(bus2.req_ready), 32'd1);
      check_value("rsp_valid_after_handoff", 32'(bus2.rsp_valid), 32'd0);
   endtask

   task automatic xact1(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic rw, output int lat);
      bus1.rsp_ready = 1'b1;
      bus1.req_valid = 1'b1;
      bus1.req_write = w;
      bus1.req_addr  = a;
      bus1.req_wdata = d;
      bus1.req_dest  = 4'h0;
      tick();
      bus1.req_valid = 1'b0;
      lat = 1;
      while (!bus1.rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!bus1.rsp_valid) check_value("l1_rsp_valid_timeout", 32'd0, 32'd1);
      rd = bus1.rsp_data;
      rw = bus1.rsp_write;
      tick();
      check_value("l1_req_ready_after_handoff", 32'(bus1.req_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] rd;
      logic        rw;
      logic [3:0]  rdst;
      int          lat;

      err_cnt = 0;
      chk_cnt = 0;
      reset   = 1'b1;
      bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
      bus2.req_wdata = '0;   bus2.req_dest  = 4'h0; bus2.rsp_ready = 1'b1;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
      bus1.req_wdata = '0;   bus1.req_dest  = 4'h0; bus1.rsp_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      check_value("reset_req_ready", 32'(bus2.req_ready), 32'd1);
      check_value("reset_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
      check_value("reset_rsp_write", 32'(bus2.rsp_write), 32'd0);
      check_value("reset_rsp_data",  32'(bus2.rsp_data),  32'd0);
      check_value("reset_rsp_dest",  32'(bus2.rsp_dest),  32'd0);

      // Store then load, same address
      xact2(1'b1, 16'h0010, 16'hBEEF, 4'h0, 0, 16'h0, rd, rw, rdst, lat);
      check_value("st_latency", 32'(lat), 32'd2);
      check_value("st_rsp_write", 32'(rw), 32'd1);
      check_value("st_rsp_data", 32'(rd), 32'hBEEF);
      xact2(1'b0, 16'h0010, 16'h0000, 4'h3, 0, 16'h0, rd, rw, rdst, lat);
      check_value("ld_latency", 32'(lat), 32'd2);
      check_value("ld_rsp_data", 32'(rd), 32'hBEEF);
      check_value("ld_rsp_dest", 32'(rdst), 32'd3);
      check_value("ld_rsp_write", 32'(rw), 32'd0);
      check_value("hold_rsp_data", 32'(bus2.rsp_data), 32'hBEEF);
      check_value("hold_rsp_dest", 32'(bus2.rsp_dest), 32'd3);

      // Backpressure on a load of a preloaded word
      xact2(1'b1, 16'h0004, 16'h1234, 4'h0, 0, 16'h0, rd, rw, rdst, lat);
      xact2(1'b0, 16'h0004, 16'h0000, 4'h5, 5, 16'h1234, rd, rw, rdst, lat);
      check_value("bp_rsp_data", 32'(rd), 32'h1234);
      check_value("bp_rsp_dest", 32'(rdst), 32'd5);

      // Store presented during BUSY and RESP must be ignored
      bus2.rsp_ready = 1'b1;
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b0;
      bus2.req_addr  = 16'h0004;
      bus2.req_dest  = 4'h1;
      tick();
      check_value("busy_req_ready", 32'(bus2.req_ready), 32'd0);
      bus2.req_write = 1'b1;
      bus2.req_wdata = 16'h0000;
      tick();
      check_value("ign_rsp_valid", 32'(bus2.rsp_valid), 32'd1);
      check_value("ign_rsp_data", 32'(bus2.rsp_data), 32'h1234);
      tick();
      bus2.req_valid = 1'b0;
      check_value("ign_req_ready", 32'(bus2.req_ready), 32'd1);
      tick();
      check_value("ign_not_accepted", 32'(bus2.req_ready), 32'd1);
      xact2(1'b0, 16'h0004, 16'h0000, 4'h2, 0, 16'h0, rd, rw, rdst, lat);
      check_value("ign_reload_data", 32'(rd), 32'h1234);

      // Reset between accept and commit discards the store
      xact2(1'b1, 16'h0020, 16'h1111, 4'h0, 0, 16'h0, rd, rw, rdst, lat);
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b1;
      bus2.req_addr  = 16'h0020;
      bus2.req_wdata = 16'hAAAA;
      tick();
      bus2.req_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_value("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
      check_value("rst_req_ready", 32'(bus2.req_ready), 32'd1);
      xact2(1'b0, 16'h0020, 16'h0000, 4'h7, 0, 16'h0, rd, rw, rdst, lat);
      check_value("rst_prior_value", 32'(rd), 32'h1111);

      // LATENCY=1 at the top address
      xact1(1'b1, 16'hFFFF, 16'h5A5A, rd, rw, lat);
      check_value("l1_st_latency", 32'(lat), 32'd1);
      check_value("l1_st_rsp_write", 32'(rw), 32'd1);
      xact1(1'b0, 16'hFFFF, 16'h0000, rd, rw, lat);
      check_value("l1_ld_latency", 32'(lat), 32'd1);
      check_value("l1_ld_data", 32'(rd), 32'h5A5A);
      check_value("l1_ld_rsp_write", 32'(rw), 32'd0);

`ifdef DMEM_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_value("stats_load_reset", 32'(load_count), 32'd0);
      check_value("stats_store_reset", 32'(store_count), 32'd0);
      check_value("stats_stall_reset", 32'(stall_count), 32'd0);
      xact2(1'b1, 16'h0030, 16'h0001, 4'h0, 0, 16'h0, rd, rw, rdst, lat);
      xact2(1'b0, 16'h0030, 16'h0000, 4'h1, 4, 16'h0001, rd, rw, rdst, lat);
      xact2(1'b1, 16'h0031, 16'h0002, 4'h0, 0, 16'h0, rd, rw, rdst, lat);
      xact2(1'b0, 16'h0031, 16'h0000, 4'h2, 0, 16'h0, rd, rw, rdst, lat);
      xact2(1'b0, 16'h0004, 16'h0000, 4'h3, 0, 16'h0, rd, rw, rdst, lat);
      check_value("stats_load_count", 32'(load_count), 32'd3);
      check_value("stats_store_count", 32'(store_count), 32'd2);
      check_value("stats_stall_count", 32'(stall_count), 32'd4);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
